// File: rtl/sal_arb_pkg.sv
// Shared types and helpers for the SAL FIFO burst arbiter and related schedulers.
package sal_arb_pkg;

    // Arbiter FSM: IDLE arbitrates, BURST pops beats from the granted FIFO.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Index width for n requesters; never narrower than one bit so that
    // index ports stay legal for small configurations.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/sal_rr_picker.sv
// Combinational round-robin picker: rotates the request vector so rr_ptr sits
// at bit 0, priority-encodes the lowest set bit, then rotates the offset back.
module sal_rr_picker
    import sal_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               any_valid,
    output logic [IDX_W-1:0]   sel_idx
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [2*NUM_REQ-1:0] shift_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [IDX_W-1:0]     off_s;
    logic                 found_s;
    logic [IDX_W:0]       sum_s;

    // Rotate, priority-encode, and map the winning offset back to an index
    always_comb begin
        dbl_s   = {req_vec, req_vec};
        shift_s = dbl_s >> rr_ptr;
        rot_s   = shift_s[NUM_REQ-1:0];
        found_s = 1'b0;
        off_s   = {IDX_W{1'b0}};
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found_s && rot_s[j]) begin
                found_s = 1'b1;
                off_s   = IDX_W'(j);
            end else begin
                found_s = found_s;
            end
        end
        sum_s = {1'b0, rr_ptr} + {1'b0, off_s};
        if (sum_s >= (IDX_W+1)'(NUM_REQ)) begin
            sum_s = sum_s - (IDX_W+1)'(NUM_REQ);
        end else begin
            sum_s = sum_s;
        end
        any_valid = found_s;
        sel_idx   = sum_s[IDX_W-1:0];
    end

endmodule

// File: rtl/sal_fifo_arbiter.sv
// Round-robin burst arbiter: grants one requester FIFO at a time for an atomic
// burst of BURST_LEN beats and forwards the popped beats through a single
// registered valid/ready output stage. A FIFO is only popped while non-empty
// and only when the output register is free or being drained this cycle.
module sal_fifo_arbiter
    import sal_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  BURST_LEN  = 4,
    localparam int IDX_W      = idx_width(NUM_REQ),
    localparam int CNT_W      = $clog2(BURST_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_empty_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rdata_i,
    output logic [NUM_REQ-1:0]            req_rden_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic [IDX_W-1:0]              out_src_o,
    output logic                          out_last_o,
    output logic                          busy_o
);

    state_t                state_r;
    logic [IDX_W-1:0]      rr_ptr_r;
    logic [IDX_W-1:0]      grant_r;
    logic [CNT_W-1:0]      beat_cnt_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [IDX_W-1:0]      out_src_r;
    logic                  out_last_r;
    logic                  busy_r;

    logic [NUM_REQ-1:0]    req_vld_s;
    logic                  any_s;
    logic [IDX_W-1:0]      pick_s;
    logic                  gnt_empty_s;
    logic [DATA_WIDTH-1:0] gnt_data_s;
    logic                  pop_s;
    logic                  last_beat_s;
    logic [IDX_W-1:0]      next_rr_s;
    logic [NUM_REQ-1:0]    rden_s;

    assign req_vld_s = ~req_empty_i;

    sal_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_vec   (req_vld_s),
        .rr_ptr    (rr_ptr_r),
        .any_valid (any_s),
        .sel_idx   (pick_s)
    );

    // Select the granted FIFO's empty flag and head data
    always_comb begin
        gnt_empty_s = 1'b1;
        gnt_data_s  = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_empty_s = (grant_r == IDX_W'(i)) ? req_empty_i[i] : gnt_empty_s;
            gnt_data_s  = (grant_r == IDX_W'(i)) ? req_rdata_i[i*DATA_WIDTH +: DATA_WIDTH]
                                                 : gnt_data_s;
        end
    end

    // Pop decision, burst-end detect, next round-robin pointer and pop strobes
    always_comb begin
        pop_s       = (state_r == BURST) && !gnt_empty_s && (!out_valid_r || out_ready_i);
        last_beat_s = (beat_cnt_r == CNT_W'(BURST_LEN - 1));
        if (grant_r == IDX_W'(NUM_REQ - 1)) begin
            next_rr_s = {IDX_W{1'b0}};
        end else begin
            next_rr_s = grant_r + IDX_W'(1);
        end
        rden_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            rden_s[i] = pop_s && (grant_r == IDX_W'(i));
        end
    end

    // Arbitration FSM together with the registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= {IDX_W{1'b0}};
            grant_r     <= {IDX_W{1'b0}};
            beat_cnt_r  <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_src_r   <= {IDX_W{1'b0}};
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (pop_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= gnt_data_s;
                out_src_r   <= grant_r;
                out_last_r  <= last_beat_s;
            end else if (out_valid_r && out_ready_i) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        grant_r    <= pick_s;
                        beat_cnt_r <= {CNT_W{1'b0}};
                        state_r    <= BURST;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                    end
                end
                BURST: begin
                    if (pop_s) begin
                        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                        if (last_beat_s) begin
                            state_r  <= IDLE;
                            rr_ptr_r <= next_rr_s;
                            busy_r   <= 1'b0;
                        end else begin
                            state_r  <= BURST;
                        end
                    end else begin
                        // Granted FIFO may be starved; hold the grant.
                        state_r <= BURST;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign req_rden_o  = rden_s;
    assign out_valid_o = out_valid_r;
    assign out_data_o  = out_data_r;
    assign out_src_o   = out_src_r;
    assign out_last_o  = out_last_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_sal_fifo_arbiter.sv
// Directed testbench for sal_fifo_arbiter with a queue-based FIFO model.
module tb_sal_fifo_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_empty_i = 4'b1111;
    logic [N*DW-1:0] req_rdata_i = '0;
    logic [N-1:0]    req_rden_o;
    logic            out_valid_o;
    logic            out_ready_i = 1'b1;
    logic [DW-1:0]   out_data_o;
    logic [1:0]      out_src_o;
    logic            out_last_o;
    logic            busy_o;

    always #5 clk = ~clk;

    sal_fifo_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_empty_i (req_empty_i),
        .req_rdata_i (req_rdata_i),
        .req_rden_o  (req_rden_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_src_o   (out_src_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o)
    );

    typedef struct {
        int          src;
        logic [31:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    logic [31:0] fq [N][$];
    beat_t       acc_q [$];

    logic [N-1:0]  s_rden;
    logic [N-1:0]  s_empty;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic [1:0]    s_src;
    logic          s_last;
    logic          s_busy;

    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;

    // Drive FIFO-side inputs from the model queues
    task automatic refresh();
        logic [N*DW-1:0] rd;
        rd = '0;
        for (int i = 0; i < N; i++) begin
            req_empty_i[i] = (fq[i].size() == 0);
            if (fq[i].size() != 0) rd[i*DW +: DW] = fq[i][0];
        end
        req_rdata_i = rd;
    endtask

    // One clock: snapshot outputs at negedge, apply pops after posedge
    task automatic tick();
        beat_t b;
        refresh();
        @(negedge clk);
        s_rden  = req_rden_o;
        s_empty = req_empty_i;
        s_valid = out_valid_o;
        s_data  = out_data_o;
        s_src   = out_src_o;
        s_last  = out_last_o;
        s_busy  = busy_o;
        if (out_valid_o && out_ready_i) begin
            b.src  = int'(out_src_o);
            b.data = out_data_o;
            b.last = out_last_o;
            b.cyc  = cyc;
            acc_q.push_back(b);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_rden[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        end
        cyc++;
        refresh();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < N; i++) fq[i].delete();
        refresh();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        acc_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int j = 0; j < 4; j++) fq[0].push_back(32'h50 + j);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid_o !== 1'b0 || req_rden_o !== 4'b0000 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: valid=%b rden=%b busy=%b, required 0 0000 0",
                     out_valid_o, req_rden_o, busy_o);
        end
        tests_run++;
        if (out_data_o !== 32'h0 || out_src_o !== 2'd0 || out_last_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_regs: data=%h src=%0d last=%b, required 0 0 0",
                     out_data_o, out_src_o, out_last_o);
        end
        for (int i = 0; i < N; i++) fq[i].delete();
        refresh();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            tests_run++;
            if (s_rden !== 4'b0000 || s_valid !== 1'b0 || s_busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_empty t=%0d: rden=%b valid=%b busy=%b, required 0000 0 0",
                         t, s_rden, s_valid, s_busy);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0]  exp_rden  [7] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic        exp_valid [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        exp_busy  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_data  [7] = '{32'h0, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0};
        logic        exp_last  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int j = 0; j < 4; j++) fq[2].push_back(32'hA0 + j);
        for (int t = 0; t < 7; t++) begin
            tick();
            tests_run++;
            if (s_rden !== exp_rden[t] || s_valid !== exp_valid[t] || s_busy !== exp_busy[t]) begin
                tests_failed++;
                $display("FAIL single_ctrl t=%0d: rden=%b valid=%b busy=%b, required %b %b %b",
                         t, s_rden, s_valid, s_busy, exp_rden[t], exp_valid[t], exp_busy[t]);
            end
            if (exp_valid[t]) begin
                tests_run++;
                if (s_data !== exp_data[t] || s_src !== 2'd2 || s_last !== exp_last[t]) begin
                    tests_failed++;
                    $display("FAIL single_beat t=%0d: data=%h src=%0d last=%b, required %h 2 %b",
                             t, s_data, s_src, s_last, exp_data[t], exp_last[t]);
                end
            end
        end
        // rr_ptr is now 3: with FIFO1 and FIFO3 both pending, FIFO3 goes first
        acc_q.delete();
        for (int j = 0; j < 4; j++) begin
            fq[1].push_back(32'hB0 + j);
            fq[3].push_back(32'hC0 + j);
        end
        for (int k = 0; k < 60 && acc_q.size() < 8; k++) tick();
        tests_run++;
        if (acc_q.size() != 8) begin
            tests_failed++;
            $display("FAIL rr_after_single: got %0d beats, required 8", acc_q.size());
        end else if (acc_q[0].src != 3 || acc_q[4].src != 1) begin
            tests_failed++;
            $display("FAIL rr_after_single: burst srcs %0d,%0d, required 3,1",
                     acc_q[0].src, acc_q[4].src);
        end
    endtask

    task automatic test_fairness();
        int b, m, esrc, gap;
        logic [31:0] edata;
        do_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 8; j++) fq[i].push_back((i << 8) | j);
        for (int k = 0; k < 300 && acc_q.size() < 32; k++) tick();
        tests_run++;
        if (acc_q.size() != 32) begin
            tests_failed++;
            $display("FAIL fair_count: got %0d beats, required 32", acc_q.size());
        end else begin
            for (int k = 0; k < 32; k++) begin
                b = k / 4;
                m = k % 4;
                esrc  = b % 4;
                edata = 32'((esrc << 8) | ((b / 4) * 4 + m));
                tests_run++;
                if (acc_q[k].src != esrc || acc_q[k].data !== edata || acc_q[k].last !== (m == 3)) begin
                    tests_failed++;
                    $display("FAIL fair_beat k=%0d: src=%0d data=%h last=%b, required %0d %h %b",
                             k, acc_q[k].src, acc_q[k].data, acc_q[k].last, esrc, edata, (m == 3));
                end
                if (k > 0) begin
                    gap = acc_q[k].cyc - acc_q[k-1].cyc;
                    tests_run++;
                    if (gap != ((m == 0) ? 2 : 1)) begin
                        tests_failed++;
                        $display("FAIL fair_gap k=%0d: gap=%0d, required %0d",
                                 k, gap, (m == 0) ? 2 : 1);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int j = 0; j < 4; j++) fq[0].push_back(32'hD0 + j);
        s_valid = 1'b0;
        for (int k = 0; k < 20 && !s_valid; k++) tick();
        // D0 was accepted and D1 loaded at the edge just passed
        out_ready_i = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            tests_run++;
            if (s_valid !== 1'b1 || s_data !== 32'hD1 || s_src !== 2'd0 || s_rden !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_hold t=%0d: valid=%b data=%h src=%0d rden=%b, required 1 d1 0 0000",
                         t, s_valid, s_data, s_src, s_rden);
            end
        end
        out_ready_i = 1'b1;
        for (int t = 0; t < 10; t++) tick();
        tests_run++;
        if (acc_q.size() != 4) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d beats, required 4", acc_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (acc_q[k].data !== 32'hD0 + k || acc_q[k].last !== (k == 3)) begin
                    tests_failed++;
                    $display("FAIL bp_beat k=%0d: data=%h last=%b, required %h %b",
                             k, acc_q[k].data, acc_q[k].last, 32'hD0 + k, (k == 3));
                end
            end
        end
    endtask

    task automatic test_starvation();
        do_reset();
        fq[1].push_back(32'h10);
        fq[1].push_back(32'h11);
        for (int j = 0; j < 4; j++) fq[3].push_back(32'h30 + j);
        for (int t = 0; t < 10; t++) begin
            tick();
            tests_run++;
            if (s_rden[3] !== 1'b0 || (s_rden & s_empty) !== 4'b0000) begin
                tests_failed++;
                $display("FAIL starve_hold t=%0d: rden=%b empty=%b, required rden[3]=0 and no pop of empty",
                         t, s_rden, s_empty);
            end
        end
        fq[1].push_back(32'h12);
        fq[1].push_back(32'h13);
        for (int k = 0; k < 60 && acc_q.size() < 8; k++) begin
            tick();
            tests_run++;
            if ((s_rden & s_empty) !== 4'b0000) begin
                tests_failed++;
                $display("FAIL starve_underflow: rden=%b empty=%b, required no overlap", s_rden, s_empty);
            end
        end
        tests_run++;
        if (acc_q.size() != 8) begin
            tests_failed++;
            $display("FAIL starve_count: got %0d beats, required 8", acc_q.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                tests_run++;
                if (acc_q[k].src != ((k < 4) ? 1 : 3) ||
                    acc_q[k].data !== ((k < 4) ? 32'h10 + k : 32'h30 + k - 4)) begin
                    tests_failed++;
                    $display("FAIL starve_order k=%0d: src=%0d data=%h, required %0d %h", k,
                             acc_q[k].src, acc_q[k].data, (k < 4) ? 1 : 3,
                             (k < 4) ? 32'h10 + k : 32'h30 + k - 4);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_head;
        do_reset();
        for (int j = 0; j < 8; j++) fq[0].push_back(32'hE0 + j);
        for (int k = 0; k < 40 && acc_q.size() < 5; k++) tick();
        for (int j = 0; j < 4; j++) fq[1].push_back(32'hF0 + j);
        for (int k = 0; k < 40 && acc_q.size() < 6; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid_o !== 1'b0 || req_rden_o !== 4'b0000 || busy_o !== 1'b0 || out_data_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL midrst_clear: valid=%b rden=%b busy=%b data=%h, required 0 0000 0 0",
                     out_valid_o, req_rden_o, busy_o, out_data_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        acc_q.delete();
        exp_head = (fq[0].size() != 0) ? fq[0][0] : 32'hDEAD_BEEF;
        for (int k = 0; k < 20 && acc_q.size() < 1; k++) tick();
        tests_run++;
        if (acc_q.size() < 1) begin
            tests_failed++;
            $display("FAIL midrst_regrant: no beat after release, required one");
        end else if (acc_q[0].src != 0 || acc_q[0].data !== exp_head) begin
            tests_failed++;
            $display("FAIL midrst_regrant: src=%0d data=%h, required 0 %h",
                     acc_q[0].src, acc_q[0].data, exp_head);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_starvation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sal_fifo_arbiter.md
Name: sal_fifo_arbiter

Overview:
Round-robin burst arbiter that shares one downstream command/data channel between NUM_REQ requester FIFOs in the SAL controller.
- Each requester is a standard SAL FIFO read side (empty, rdata, rden).
- The block grants one FIFO at a time for an atomic burst of BURST_LEN beats.
- Popped beats go through a single registered output stage with a valid/ready handshake.
- It guarantees no FIFO is ever read while empty and no beat is lost under backpressure.

Parameters:
NUM_REQ, 4, number of requester FIFOs (2..16)
DATA_WIDTH, 32, beat width
BURST_LEN, 4, beats popped per grant (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
req_empty_i  in  NUM_REQ  per-FIFO empty flag
req_rdata_i  in  NUM_REQ*DATA_WIDTH  per-FIFO head data; FIFO i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_rden_o  out  NUM_REQ  per-FIFO pop strobe, one-hot or zero
out_valid_o  out  1  output beat valid
out_ready_i  in  1  downstream accepts beat
out_data_o  out  DATA_WIDTH  output beat
out_src_o  out  clog2(NUM_REQ)  index of the FIFO that supplied out_data_o
out_last_o  out  1  final beat of the burst
busy_o  out  1  state != IDLE

Behaviour:
- Reset values (asynchronous, immediate on rst_n low):
  - State IDLE, rr_ptr=0, grant=0, beat_cnt=0.
  - out_valid_o=0, out_data_o=0, out_src_o=0, out_last_o=0, req_rden_o=0, busy_o=0.
- FSM states: IDLE, BURST.
- IDLE:
  - If any ~req_empty_i, select the first non-empty index searching upward from rr_ptr with wrap (rr_ptr has highest priority).
  - Register that index as grant, clear beat_cnt, go to BURST.
  - No pop occurs in the IDLE cycle.
- BURST pop condition: pop = ~req_empty_i[grant] & (~out_valid_o | out_ready_i).
  - req_rden_o[grant]=pop, driven combinationally; all other rden bits are 0.
- On pop:
  - out_data_o <= req_rdata_i[grant], out_src_o <= grant, out_valid_o <= 1.
  - out_last_o <= (beat_cnt==BURST_LEN-1); beat_cnt increments.
- On the pop with beat_cnt==BURST_LEN-1:
  - Go to IDLE; rr_ptr <= grant+1, wrapping NUM_REQ-1 -> 0.
- Output register when not popping:
  - If out_ready_i & out_valid_o: out_valid_o <= 0.
  - Otherwise out_data_o, out_src_o and out_last_o hold.
  - Data is stable while valid & ~ready.
- Latency: the first beat appears 2 cycles after req_empty_i deasserts (IDLE pick, BURST pop). With ready held high, subsequent beats are back-to-back.
- Throughput: one idle cycle between consecutive bursts (the IDLE arbitration cycle).
- Granted FIFO runs empty mid-burst:
  - Grant is held and no other requester is served; the burst is atomic.
  - Pops resume as soon as the FIFO is non-empty.
  - No timeout.
- Underflow safety: req_rden_o[i] is never 1 while req_empty_i[i]=1.
- Simultaneous pop and accept in the same cycle: the register reloads, and out_valid_o stays 1.
- A requester that becomes non-empty during another's burst waits for the next IDLE arbitration.
- beat_cnt width is clog2(BURST_LEN+1); the counter never wraps within a burst.
- Reset mid-burst: the burst is abandoned with no completion.
  - FIFO-side state is the requester's responsibility.
  - After release, arbitration restarts at rr_ptr=0.

Decomposition:
- Package sal_arb_pkg:
  - Arbiter FSM enum, state_t {IDLE, BURST}.
  - Helper localparam function for the index width, clog2 of NUM_REQ, with minimum 1.
- Sub-module sal_rr_picker, purely combinational:
  - Inputs: request vector and rr_ptr.
  - Outputs: any_valid and the selected index, via a rotate-then-priority-encode scheme.
  - Reusable by later bank schedulers.

Test Plan:
All scenarios use NUM_REQ=4, BURST_LEN=4, DATA_WIDTH=32.
1. Reset: hold rst_n=0, then assert it asynchronously mid-cycle -> out_valid_o=0, req_rden_o=4'b0000 and busy_o=0 before the next clk edge. After release, idle with all FIFOs empty -> no rden ever.
2. Single requester: FIFO2 holds 0xA0..0xA3, out_ready_i=1.
   - req_rden_o=4'b0100 for 4 consecutive cycles starting 1 cycle after empty deasserts.
   - out_data_o=A0,A1,A2,A3 on consecutive cycles, out_src_o=2, out_last_o only with A3.
   - Then IDLE with rr_ptr=3.
3. Fairness: all four FIFOs hold 8 beats each -> burst source order 0,1,2,3,0,1,2,3; each burst exactly 4 beats; 1 idle cycle between bursts.
4. Backpressure: out_ready_i=0 for 5 cycles while out_valid_o=1 -> out_data_o and out_src_o stable, req_rden_o=0. When ready returns, beats resume with none dropped or duplicated (scoreboard compare).
5. Mid-burst starvation: FIFO1 has 2 beats and FIFO3 has 4; FIFO1 receives 2 more beats 10 cycles later.
   - Grant stays on 1, and FIFO3 is untouched until FIFO1's 4th beat.
   - req_rden_o[1] is never asserted while req_empty_i[1]=1.
6. Reset mid-burst: assert rst_n=0 after beat 2 of FIFO0's burst -> outputs cleared immediately. After release with FIFO0 and FIFO1 non-empty, the next grant is 0 (rr_ptr=0).
